ysyx_22050133_mem_arbiter: RTL and testbench

- Shares the core's single 64-bit memory port between the instruction-fetch requester (IFU) and the load/store requester (LSU).
- Sequences one outstanding memory transaction at a time and routes each response back to its owner.
- Discards fetch responses invalidated by a pipeline flush.
- Bounds LSU priority so fetch cannot starve.

---
 rtl/ysyx_22050133_mem_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_ysyx_22050133_mem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050133_mem_arbiter.sv
// ysyx_22050133_mem_arbiter
//
// Shares one 64-bit memory port between the instruction-fetch unit (IFU) and
// the load/store unit (LSU). Exactly one memory transaction is outstanding at
// a time. Each response is routed back to the requester that issued it.
// Fetch responses invalidated by a flush are discarded. LSU priority is
// bounded so that a waiting fetch cannot starve.
//
// Ports:
//   clk, rst               core clock; asynchronous active-low reset (0 = reset)
//   if_req_valid/ready     IFU request handshake; if_addr is the fetch address
//   if_flush               kills any in-flight or pending fetch
//   if_rsp_valid/if_rdata  fetch response (1-cycle pulse) and data
//   ls_req_valid/ready     LSU request handshake; ls_addr/wen/wdata/wmask payload
//   ls_rsp_valid/ls_rdata  LSU response (1-cycle pulse, also acks writes) and data
//   mem_req_valid/ready    memory request handshake; mem_* carry registered payload
//   mem_rsp_valid/rdata    memory response and read data
//
// Parameters:
//   MAX_LS_STREAK          consecutive LSU grants allowed while a fetch waits

module ysyx_22050133_mem_arbiter #(
  parameter int unsigned MAX_LS_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_rsp_valid,
  output logic [63:0] if_rdata,

  input  logic        ls_req_valid,
  output logic        ls_req_ready,
  input  logic [31:0] ls_addr,
  input  logic        ls_wen,
  input  logic [63:0] ls_wdata,
  input  logic [7:0]  ls_wmask,
  output logic        ls_rsp_valid,
  output logic [63:0] ls_rdata,

  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_rsp_valid,
  input  logic [63:0] mem_rdata
);

  localparam int unsigned STREAK_W = $clog2(MAX_LS_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LS_STREAK);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT
  } state_e;

  typedef enum logic {
    OWN_IF,
    OWN_LS
  } owner_e;

  state_e               state_q,         state_d;
  owner_e               owner_q,         owner_d;
  logic                 drop_q,          drop_d;
  logic [STREAK_W-1:0]  ls_streak_q,     ls_streak_d;
  logic                 arb_en_q,        arb_en_d;

  logic                 mem_req_valid_q, mem_req_valid_d;
  logic [31:0]          mem_addr_q,      mem_addr_d;
  logic                 mem_wen_q,       mem_wen_d;
  logic [63:0]          mem_wdata_q,     mem_wdata_d;
  logic [7:0]           mem_wmask_q,     mem_wmask_d;

  logic                 if_rsp_valid_q,  if_rsp_valid_d;
  logic [63:0]          if_rdata_q,      if_rdata_d;
  logic                 ls_rsp_valid_q,  ls_rsp_valid_d;
  logic [63:0]          ls_rdata_q,      ls_rdata_d;

  logic                 ls_grant;
  logic                 if_grant;

  // arb_en_q clears asynchronously with reset and sets on the first clock
  // after release. Gating the combinational readys with it keeps them low
  // while reset is held, without feeding the async reset net into logic.
  always_comb begin
    ls_grant = 1'b0;
    if_grant = 1'b0;
    if (state_q == ST_IDLE && arb_en_q) begin
      ls_grant = ls_req_valid && !(if_req_valid && (ls_streak_q == STREAK_MAX));
      if_grant = !ls_grant && if_req_valid && !if_flush;
    end
  end

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    drop_d          = drop_q;
    ls_streak_d     = ls_streak_q;
    arb_en_d        = 1'b1;
    mem_req_valid_d = mem_req_valid_q;
    mem_addr_d      = mem_addr_q;
    mem_wen_d       = mem_wen_q;
    mem_wdata_d     = mem_wdata_q;
    mem_wmask_d     = mem_wmask_q;
    if_rsp_valid_d  = 1'b0;
    if_rdata_d      = if_rdata_q;
    ls_rsp_valid_d  = 1'b0;
    ls_rdata_d      = ls_rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        drop_d = 1'b0;
        if (ls_grant) begin
          state_d         = ST_REQ;
          owner_d         = OWN_LS;
          mem_req_valid_d = 1'b1;
          mem_addr_d      = ls_addr;
          mem_wen_d       = ls_wen;
          mem_wdata_d     = ls_wdata;
          mem_wmask_d     = ls_wmask;
          // Streak only grows while a fetch is actually waiting.
          if (!if_req_valid) begin
            ls_streak_d = '0;
          end else if (ls_streak_q != STREAK_MAX) begin
            ls_streak_d = ls_streak_q + 1'b1;
          end
        end else if (if_grant) begin
          state_d         = ST_REQ;
          owner_d         = OWN_IF;
          mem_req_valid_d = 1'b1;
          mem_addr_d      = if_addr;
          mem_wen_d       = 1'b0;
          mem_wdata_d     = '0;
          mem_wmask_d     = '0;
          ls_streak_d     = '0;
        end
      end

      ST_REQ: begin
        if (owner_q == OWN_IF && if_flush) begin
          drop_d = 1'b1;
        end
        if (mem_req_ready) begin
          state_d         = ST_WAIT;
          mem_req_valid_d = 1'b0;
        end
      end

      ST_WAIT: begin
        if (owner_q == OWN_IF && if_flush) begin
          drop_d = 1'b1;
        end
        if (mem_rsp_valid) begin
          state_d = ST_IDLE;
          drop_d  = 1'b0;
          if (owner_q == OWN_LS) begin
            ls_rsp_valid_d = 1'b1;
            ls_rdata_d     = mem_rdata;
          end else if (!(drop_q || if_flush)) begin
            // A flush arriving with the response still kills it.
            if_rsp_valid_d = 1'b1;
            if_rdata_d     = mem_rdata;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= ST_IDLE;
      owner_q         <= OWN_IF;
      drop_q          <= 1'b0;
      ls_streak_q     <= '0;
      arb_en_q        <= 1'b0;
      mem_req_valid_q <= 1'b0;
      mem_addr_q      <= '0;
      mem_wen_q       <= 1'b0;
      mem_wdata_q     <= '0;
      mem_wmask_q     <= '0;
      if_rsp_valid_q  <= 1'b0;
      if_rdata_q      <= '0;
      ls_rsp_valid_q  <= 1'b0;
      ls_rdata_q      <= '0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      drop_q          <= drop_d;
      ls_streak_q     <= ls_streak_d;
      arb_en_q        <= arb_en_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_addr_q      <= mem_addr_d;
      mem_wen_q       <= mem_wen_d;
      mem_wdata_q     <= mem_wdata_d;
      mem_wmask_q     <= mem_wmask_d;
      if_rsp_valid_q  <= if_rsp_valid_d;
      if_rdata_q      <= if_rdata_d;
      ls_rsp_valid_q  <= ls_rsp_valid_d;
      ls_rdata_q      <= ls_rdata_d;
    end
  end

  assign if_req_ready  = if_grant;
  assign ls_req_ready  = ls_grant;
  assign if_rsp_valid  = if_rsp_valid_q;
  assign if_rdata      = if_rdata_q;
  assign ls_rsp_valid  = ls_rsp_valid_q;
  assign ls_rdata      = ls_rdata_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wen       = mem_wen_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_wmask     = mem_wmask_q;

endmodule

// File: tb/tb_ysyx_22050133_mem_arbiter.sv
module tb_ysyx_22050133_mem_arbiter;

  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, if_req_ready, if_flush, if_rsp_valid;
  logic [31:0] if_addr;
  logic [63:0] if_rdata;
  logic        ls_req_valid, ls_req_ready, ls_wen, ls_rsp_valid;
  logic [31:0] ls_addr;
  logic [63:0] ls_wdata, ls_rdata;
  logic [7:0]  ls_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;

  always #5 clk = ~clk;

  ysyx_22050133_mem_arbiter #(.MAX_LS_STREAK(MAXS)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_flush(if_flush), .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
    .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
    .ls_rsp_valid(ls_rsp_valid), .ls_rdata(ls_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
  );

  typedef struct {
    bit          is_ls;
    bit          drop;
    bit          chk_data;
    logic [63:0] data;
  } rsp_t;

  typedef enum {P_IDLE, P_REQ, P_WAIT} phase_e;

  rsp_t        sb[$];
  bit          glog[$];
  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  phase_e      ph = P_IDLE;
  int          if_n = 0, ls_n = 0, if_k = 0, ls_k = 0;
  logic [31:0] if_base = 32'h8000_0000, ls_base = 32'h8000_2000;
  bit          ls_wen_cfg = 1'b0;
  logic [7:0]  ls_mask_cfg = 8'h00;
  logic [63:0] ls_wdata_cfg = 64'h1111_2222_3333_4444;
  int          ready_delay = 0, rsp_delay = 0, hold_cnt = 0, wait_cnt = 0;
  bit          flush_in_wait = 0, flush_on_rsp = 0, flush_idle = 0, stray_rsp = 0;
  bit          fixed_en = 0;
  logic [63:0] fixed_data = '0;
  int          streak = 0;
  bit          cur_ls = 0;
  logic [31:0] e_addr = '0;
  bit          e_wen = 0;
  logic [63:0] e_wdata = '0;
  logic [7:0]  e_wmask = '0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: response scoreboard, requesters, memory model,
  // and a reference arbitration model.
  task automatic cyc();
    rsp_t   e;
    bit     lg, ig;
    phase_e p;
    @(negedge clk); #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk1("if_rsp_valid", if_rsp_valid, !e.is_ls && !e.drop);
      chk1("ls_rsp_valid", ls_rsp_valid, e.is_ls);
      if (e.chk_data && e.is_ls)  chk64("ls_rdata", ls_rdata, e.data);
      if (e.chk_data && !e.is_ls) chk64("if_rdata", if_rdata, e.data);
    end else begin
      chk1("if_rsp_quiet", if_rsp_valid, 1'b0);
      chk1("ls_rsp_quiet", ls_rsp_valid, 1'b0);
    end

    p             = ph;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    if_flush      = 1'b0;
    if_req_valid  = (if_n > 0);
    if_addr       = if_base + 32'(4 * if_k);
    ls_req_valid  = (ls_n > 0);
    ls_addr       = ls_base + 32'(8 * ls_k);
    ls_wen        = ls_wen_cfg;
    ls_wdata      = ls_wdata_cfg + 64'(ls_k);
    ls_wmask      = ls_mask_cfg;
    if (p == P_IDLE && flush_idle) if_flush = 1'b1;
    if (p == P_IDLE && stray_rsp) begin
      mem_rsp_valid = 1'b1;
      mem_rdata     = 64'h5A5A_5A5A_A5A5_A5A5;
    end
    if (p == P_WAIT && wait_cnt == 0 && flush_in_wait) if_flush = 1'b1;
    if (p == P_WAIT && wait_cnt == rsp_delay) begin
      if (flush_on_rsp) if_flush = 1'b1;
      mem_rsp_valid = 1'b1;
      mem_rdata     = fixed_en ? fixed_data : {~e_addr, e_addr};
    end
    #1;

    lg = (p == P_IDLE) && ls_req_valid && !(if_req_valid && streak == MAXS);
    ig = (p == P_IDLE) && !lg && if_req_valid && !if_flush;
    chk1("ls_req_ready", ls_req_ready, lg);
    chk1("if_req_ready", if_req_ready, ig);

    case (p)
      P_IDLE: chk1("mem_req_valid_idle", mem_req_valid, 1'b0);
      P_REQ: begin
        chk1("mem_req_valid_req", mem_req_valid, 1'b1);
        chk64("mem_addr", 64'(mem_addr), 64'(e_addr));
        chk1("mem_wen", mem_wen, e_wen);
        chk64("mem_wmask", 64'(mem_wmask), 64'(e_wmask));
        if (e_wen) chk64("mem_wdata", mem_wdata, e_wdata);
        if (hold_cnt == ready_delay) begin
          mem_req_ready = 1'b1;
          ph            = P_WAIT;
          wait_cnt      = 0;
        end else begin
          hold_cnt++;
        end
      end
      P_WAIT: begin
        chk1("mem_req_valid_wait", mem_req_valid, 1'b0);
        if (wait_cnt == rsp_delay) begin
          e.is_ls    = cur_ls;
          e.drop     = !cur_ls && (flush_in_wait || flush_on_rsp);
          e.chk_data = !(cur_ls && e_wen) && !e.drop;
          e.data     = mem_rdata;
          sb.push_back(e);
          ph = P_IDLE;
        end else begin
          wait_cnt++;
        end
      end
      default: ;
    endcase

    if (lg) begin
      glog.push_back(1'b1);
      streak = if_req_valid ? ((streak < MAXS) ? streak + 1 : MAXS) : 0;
      cur_ls = 1; e_addr = ls_addr; e_wen = ls_wen; e_wdata = ls_wdata; e_wmask = ls_wmask;
      ls_n--; ls_k++; ph = P_REQ; hold_cnt = 0;
    end else if (ig) begin
      glog.push_back(1'b0);
      streak = 0;
      cur_ls = 0; e_addr = if_addr; e_wen = 0; e_wdata = '0; e_wmask = '0;
      if_n--; if_k++; ph = P_REQ; hold_cnt = 0;
    end
  endtask

  task automatic run(input int max_cyc);
    bit done;
    for (int i = 0; i < max_cyc; i++) begin
      if (if_n == 0 && ls_n == 0 && ph == P_IDLE && sb.size() == 0) break;
      cyc();
    end
    done = (if_n == 0 && ls_n == 0 && ph == P_IDLE && sb.size() == 0);
    chk1("run_completes", done, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit exp_order[6];
    int wait_guard;
    exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    rst = 1'b0;
    if_req_valid = 0; if_addr = '0; if_flush = 0;
    ls_req_valid = 0; ls_addr = '0; ls_wen = 0; ls_wdata = '0; ls_wmask = '0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk1("rst_mem_req_valid", mem_req_valid, 1'b0);
    chk64("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk1("rst_if_rsp_valid", if_rsp_valid, 1'b0);
    chk1("rst_ls_rsp_valid", ls_rsp_valid, 1'b0);
    rst = 1'b1;
    cyc();

    // Fetch only with fixed response data.
    fixed_en = 1; fixed_data = 64'h0000_0013_0010_0093;
    if_base = 32'h8000_0000; if_k = 0; if_n = 1;
    ready_delay = 0; rsp_delay = 2;
    run(30);
    fixed_en = 0;

    // Both valid at once: LSU first, IFU right after LSU response.
    glog.delete();
    if_n = 1; ls_n = 1; rsp_delay = 1;
    run(40);
    chk1("both_first_ls", glog.size() > 0 ? glog[0] : 1'b0, 1'b1);
    chk1("both_second_if", glog.size() > 1 ? glog[1] : 1'b1, 1'b0);

    // Streak limit: LS x4 then IF.
    glog.delete();
    if_n = 2; ls_n = 6; rsp_delay = 0;
    run(200);
    for (int i = 0; i < 6; i++) begin
      chk1("grant_order", glog.size() > i ? glog[i] : ~exp_order[i], exp_order[i]);
    end

    // Write stalled by memory for 5 cycles.
    ls_base = 32'h8000_1000; ls_k = 0; ls_wen_cfg = 1; ls_mask_cfg = 8'hF0;
    ls_wdata_cfg = 64'hDEAD_BEEF_CAFE_F00D;
    ls_n = 1; ready_delay = 5; rsp_delay = 1;
    run(40);
    ls_wen_cfg = 0; ls_mask_cfg = 8'h00; ready_delay = 0;

    // Flush while waiting, then flush with the response, then a clean fetch.
    flush_in_wait = 1; if_n = 1; rsp_delay = 3;
    run(40);
    flush_in_wait = 0; flush_on_rsp = 1; if_n = 1; rsp_delay = 2;
    run(40);
    flush_on_rsp = 0; if_n = 1;
    run(40);

    // Flush in IDLE blocks the fetch grant.
    flush_idle = 1; if_n = 1;
    repeat (3) cyc();
    flush_idle = 0;
    run(40);

    // Asynchronous reset while waiting on memory.
    if_n = 1; rsp_delay = 20;
    wait_guard = 0;
    while (ph != P_WAIT && wait_guard < 20) begin
      cyc();
      wait_guard++;
    end
    chk1("reached_wait", ph == P_WAIT, 1'b1);
    cyc();
    @(posedge clk); #3;
    rst = 1'b0;
    if_req_valid = 1'b1; ls_req_valid = 1'b1;
    #1;
    chk1("arst_if_req_ready", if_req_ready, 1'b0);
    chk1("arst_ls_req_ready", ls_req_ready, 1'b0);
    chk1("arst_mem_req_valid", mem_req_valid, 1'b0);
    chk64("arst_mem_addr", 64'(mem_addr), 64'd0);
    chk1("arst_mem_wen", mem_wen, 1'b0);
    chk64("arst_mem_wdata", mem_wdata, 64'd0);
    chk64("arst_mem_wmask", 64'(mem_wmask), 64'd0);
    chk1("arst_if_rsp_valid", if_rsp_valid, 1'b0);
    chk1("arst_ls_rsp_valid", ls_rsp_valid, 1'b0);
    chk64("arst_if_rdata", if_rdata, 64'd0);
    chk64("arst_ls_rdata", ls_rdata, 64'd0);
    ph = P_IDLE; sb.delete(); if_n = 0; ls_n = 0; streak = 0;
    @(negedge clk);
    rst = 1'b1;
    stray_rsp = 1;
    cyc();
    stray_rsp = 0;
    cyc();
    if_n = 1; ls_n = 1; rsp_delay = 1;
    run(40);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
